// File: rtl/pattern_scan_ctrl.sv
// pattern_scan_ctrl: sequences one bit-serial pattern-detection pass.
// The host programs pattern/length/window and pulses start. Accepted bits are
// shifted in, overlapping matches raise a registered match flag and bump a
// saturating counter, and done pulses for one cycle when the scan ends.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   IDLE   | waiting for start; count, err and configuration are held
//   LOAD   | one cycle: clear shift register, fill, bit and match counters
//   SCAN   | accept bits while in_valid; leave on window end or stop
//   DONE   | one cycle: done=1, then back to IDLE
module pattern_scan_ctrl #(
   parameter int PW = 8,
   parameter int CW = 8,
   localparam int LW = $clog2(PW + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          stop,
   input  logic [PW-1:0] cfg_pattern,
   input  logic [LW-1:0] cfg_len,
   input  logic [CW-1:0] cfg_bits,
   input  logic          in_bit,
   input  logic          in_valid,
   output logic          in_ready,
   output logic          busy,
   output logic          match,
   output logic [CW-1:0] match_count,
   output logic          done,
   output logic          err
);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SCAN, S_DONE} state_t;

   state_t        state_q;
   logic [PW-1:0] pat_q;
   logic [LW-1:0] len_q;
   logic [CW-1:0] bits_q;
   // The oldest bit of a full-width window is only needed for the compare on
   // the shifted value, so storage keeps PW-1 bits.
   logic [PW-2:0] sr_q;
   logic [LW-1:0] fill_q;
   logic [CW-1:0] bitcnt_q;
   logic [CW-1:0] match_count_q;
   logic          match_q;
   logic          done_q;
   logic          err_q;

   logic [PW-1:0] sr_d;
   logic [LW-1:0] fill_d;
   logic [CW-1:0] bitcnt_d;
   logic [PW-1:0] mask;
   logic          accept;
   logic          hit;
   logic          last_bit;
   logic          len_ok;

   // Post-shift view of the scan state used for the match and end decisions.
   always_comb begin
      sr_d     = {sr_q, in_bit};
      fill_d   = (fill_q < len_q) ? fill_q + 1'b1 : len_q;
      bitcnt_d = bitcnt_q + 1'b1;
      mask     = ~({PW{1'b1}} << len_q);
      accept   = (state_q == S_SCAN) && in_valid;
      hit      = (fill_d == len_q) && ((sr_d & mask) == (pat_q & mask));
      last_bit = accept && (bits_q != '0) && (bitcnt_d == bits_q);
      len_ok   = (cfg_len != '0) && (cfg_len <= LW'(PW));
   end

   // Sequencer, scan datapath and registered flags.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= S_IDLE;
         pat_q         <= '0;
         len_q         <= '0;
         bits_q        <= '0;
         sr_q          <= '0;
         fill_q        <= '0;
         bitcnt_q      <= '0;
         match_count_q <= '0;
         match_q       <= 1'b0;
         done_q        <= 1'b0;
         err_q         <= 1'b0;
      end else begin
         match_q <= 1'b0;
         done_q  <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  if (len_ok) begin
                     pat_q   <= cfg_pattern;
                     len_q   <= cfg_len;
                     bits_q  <= cfg_bits;
                     err_q   <= 1'b0;
                     state_q <= S_LOAD;
                  end else begin
                     err_q <= 1'b1;
                  end
               end
            end
            S_LOAD: begin
               sr_q          <= '0;
               fill_q        <= '0;
               bitcnt_q      <= '0;
               match_count_q <= '0;
               state_q       <= S_SCAN;
            end
            S_SCAN: begin
               if (accept) begin
                  sr_q     <= sr_d[PW-2:0];
                  fill_q   <= fill_d;
                  bitcnt_q <= bitcnt_d;
                  if (hit) begin
                     match_q <= 1'b1;
                     if (!(&match_count_q)) begin
                        match_count_q <= match_count_q + 1'b1;
                     end
                  end
               end
               if (stop || last_bit) begin
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign in_ready    = (state_q == S_SCAN);
   assign busy        = (state_q == S_LOAD) || (state_q == S_SCAN);
   assign match       = match_q;
   assign match_count = match_count_q;
   assign done        = done_q;
   assign err         = err_q;

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Scoreboard bench for pattern_scan_ctrl. Stimulus pushes the expected
// response for every bit it offers during a scan; a negedge monitor pops and
// compares whenever the DUT accepted a bit in the previous cycle.
module tb_pattern_scan_ctrl;
   localparam int PW = 8;
   localparam int CW = 4;
   localparam int LW = 4;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          reset;
   logic          start, stop, in_bit, in_valid;
   logic [PW-1:0] cfg_pattern;
   logic [LW-1:0] cfg_len;
   logic [CW-1:0] cfg_bits;
   logic          in_ready, busy, match, done, err;
   logic [CW-1:0] match_count;

   pattern_scan_ctrl #(.PW(PW), .CW(CW)) dut (
      .clk(clk), .reset(reset), .start(start), .stop(stop),
      .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_bits(cfg_bits),
      .in_bit(in_bit), .in_valid(in_valid), .in_ready(in_ready), .busy(busy),
      .match(match), .match_count(match_count), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct {int m; int cnt; int d;} exp_t;
   exp_t exp_q[$];
   int   done_q[$];

   int n_cmp = 0;
   int n_bad = 0;

   // reference model state: accepted-bit history, newest at the back
   bit          hist[$];
   logic [7:0]  m_pat;
   int          m_len, m_bits, m_cnt, m_n;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model one accepted bit; returns 1 if this bit ends the scan.
   function automatic bit model_bit(input bit b, input bit stp);
      exp_t e;
      bit   h;
      bit   fin;
      hist.push_back(b);
      m_n++;
      h = (hist.size() >= m_len);
      if (h) begin
         for (int k = 0; k < m_len; k++)
            if (hist[hist.size() - 1 - k] != m_pat[k]) h = 0;
      end
      if (h && m_cnt < CMAX) m_cnt++;
      fin = stp || (m_bits != 0 && m_n == m_bits);
      e.m = int'(h); e.cnt = m_cnt; e.d = int'(fin);
      exp_q.push_back(e);
      return fin;
   endfunction

   // monitor
   initial begin
      bit   acc_prev;
      exp_t e;
      acc_prev = 0;
      forever begin
         @(negedge clk);
         if (reset) begin
            acc_prev = 0;
            continue;
         end
         if (acc_prev) begin
            if (exp_q.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL unexpected_accept: got accept expected none at %0t", $time);
            end else begin
               e = exp_q.pop_front();
               chk("match", 32'(match), e.m);
               chk("match_count", 32'(match_count), e.cnt);
               chk("done_on_bit", 32'(done), e.d);
            end
         end else begin
            chk("match_idle", 32'(match), 0);
            if (done) begin
               if (done_q.size() == 0) begin
                  n_cmp++; n_bad++;
                  $display("FAIL unexpected_done: got done=1 expected 0 at %0t", $time);
               end else begin
                  chk("stop_done_count", 32'(match_count), done_q.pop_front());
               end
            end
         end
         acc_prev = in_valid && in_ready;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   // stream bit i (LSB first) is the i-th bit sent when use_stream is set
   task automatic run_scan(input logic [7:0] pat, input int len, input int bits, input int nb,
                           input logic [31:0] stream, input bit use_stream, input int gap,
                           input int stop_at);
      bit ended;
      int g;
      bit b;
      bit stp;
      @(posedge clk); #1;
      cfg_pattern = pat; cfg_len = LW'(len); cfg_bits = CW'(bits); start = 1;
      m_pat = pat; m_len = len; m_bits = bits; m_cnt = 0; m_n = 0;
      hist.delete();
      @(posedge clk); #1;
      start = 0;
      cfg_pattern = 8'($urandom); cfg_len = LW'($urandom); cfg_bits = CW'($urandom);
      chk("busy_load", 32'(busy), 1);
      chk("err_clear", 32'(err), 0);
      chk("ready_load", 32'(in_ready), 0);
      @(posedge clk); #1;
      chk("ready_scan", 32'(in_ready), 1);
      ended = 0;
      for (int i = 0; i < nb && !ended; i++) begin
         g = (gap >= 0) ? gap : int'($urandom_range(0, 3));
         repeat (g) begin
            in_valid = 0; in_bit = 1'($urandom); stop = 0;
            start = 1'($urandom_range(0, 1)); cfg_len = LW'($urandom);
            @(posedge clk); #1;
            start = 0;
            chk("busy_gap", 32'(busy), 1);
         end
         b   = use_stream ? stream[i] : 1'($urandom);
         stp = (stop_at == i + 1);
         in_valid = 1; in_bit = b; stop = stp;
         ended = model_bit(b, stp);
         @(posedge clk); #1;
      end
      in_valid = 0; stop = 0;
      if (!ended) begin
         stop = 1;
         done_q.push_back(m_cnt);
         @(posedge clk); #1;
         stop = 0;
      end
      chk("busy_done", 32'(busy), 0);
      in_valid = 1; in_bit = 1'($urandom);
      @(posedge clk); #1;
      in_valid = 0;
      chk("busy_idle", 32'(busy), 0);
      chk("ready_idle", 32'(in_ready), 0);
      chk("done_pulse_len", 32'(done), 0);
      chk("count_held", 32'(match_count), m_cnt);
   endtask

   task automatic bad_start(input int len);
      @(posedge clk); #1;
      cfg_len = LW'(len); cfg_pattern = 8'($urandom); start = 1; stop = 1;
      @(posedge clk); #1;
      start = 0; stop = 0;
      chk("err_set", 32'(err), 1);
      chk("err_busy", 32'(busy), 0);
      chk("err_count_held", 32'(match_count), m_cnt);
      @(posedge clk); #1;
      chk("err_idle", 32'(in_ready), 0);
      chk("err_hold", 32'(err), 1);
   endtask

   initial begin
      int nb;
      reset = 1; start = 0; stop = 0; in_bit = 0; in_valid = 0;
      cfg_pattern = '0; cfg_len = '0; cfg_bits = '0;
      m_cnt = 0;
      #1;
      chk("rst_match", 32'(match), 0);
      chk("rst_count", 32'(match_count), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_err", 32'(err), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_ready", 32'(in_ready), 0);
      @(posedge clk); #1;
      reset = 0;

      run_scan(8'b1010, 4, 6, 6, 32'b010101, 1, 0, 0);
      run_scan(8'b1010, 4, 6, 6, 32'b010101, 1, 2, 0);
      bad_start(0);
      bad_start(9);
      run_scan(8'b101, 3, 6, 3, 32'b101, 1, 0, 0);
      run_scan(8'h01, 1, 0, 20, 32'hFFFFFFFF, 1, 0, 20);

      // reset in the middle of a scan
      @(posedge clk); #1;
      cfg_pattern = 8'h01; cfg_len = 4'd1; cfg_bits = '0; start = 1;
      m_pat = 8'h01; m_len = 1; m_bits = 0; m_cnt = 0; m_n = 0; hist.delete();
      @(posedge clk); #1;
      start = 0;
      @(posedge clk); #1;
      repeat (3) begin
         in_valid = 1; in_bit = 1;
         void'(model_bit(1, 0));
         @(posedge clk); #1;
      end
      in_valid = 1; in_bit = 1;
      #2;
      reset = 1;
      exp_q.delete(); done_q.delete();
      #1;
      chk("arst_match", 32'(match), 0);
      chk("arst_count", 32'(match_count), 0);
      chk("arst_done", 32'(done), 0);
      chk("arst_busy", 32'(busy), 0);
      chk("arst_ready", 32'(in_ready), 0);
      in_valid = 0;
      @(posedge clk); #1;
      chk("arst_hold_done", 32'(done), 0);
      reset = 0;
      m_cnt = 0;
      run_scan(8'b0110, 4, 12, 12, 32'($urandom), 1, -1, 0);

      for (int t = 0; t < 40; t++) begin
         nb = int'($urandom_range(1, 20));
         run_scan(8'($urandom), int'($urandom_range(1, 8)), int'($urandom_range(0, 15)), nb,
                  32'($urandom), 0, -1,
                  ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, nb)) : 0);
      end

      repeat (3) @(posedge clk);
      #1;
      chk("exp_queue_drained", 32'(exp_q.size()), 0);
      chk("done_queue_drained", 32'(done_q.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
